// File: rtl/push_button_toggle.sv
// Debounced push button: one-cycle press pulse, latched toggle level and clean button state.
// Optional auto-repeat while held is compiled in with `define BTN_AUTO_REPEAT_EN.
module push_button_toggle #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 12500000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press,
    output logic o_level,
    output logic o_stable
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_C   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Every count must be representable in the shared counter so the equality compares can hit.
    localparam bit CFG_OK_C = (DEBOUNCE_CYCLES >= 32'd1)
                           && ((64'(DEBOUNCE_CYCLES) >> CNT_W) == 64'd0)
                           && ((64'(REPEAT_DELAY)    >> CNT_W) == 64'd0)
                           && ((64'(REPEAT_PERIOD)   >> CNT_W) == 64'd0);

    if (!CFG_OK_C) begin : g_cfg_out_of_range
    end

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       sync_r;
    logic             btn_s;
    logic             press_r, press_s;
    logic             level_r, level_s;
    logic             stable_r, stable_s;
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DLY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPT_PER_C = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    logic             rpt_r, rpt_s;
`endif

    assign btn_s = sync_r[1];

    // Two-flop synchronizer for the asynchronous button pin.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], i_btn};
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= IDLE;
            cnt_r    <= ZERO_C;
            press_r  <= 1'b0;
            level_r  <= 1'b0;
            stable_r <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_r    <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            press_r  <= press_s;
            level_r  <= level_s;
            stable_r <= stable_s;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_r    <= rpt_s;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        press_s  = 1'b0;
        level_s  = level_r;
        stable_s = stable_r;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_s    = rpt_r;
`endif
        case (state_r)
            IDLE: begin
                stable_s = 1'b0;
                if (btn_s) begin
                    state_s = PRESS_WAIT;
                    cnt_s   = ONE_C;
                end else begin
                    cnt_s   = ZERO_C;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_s = IDLE;
                    cnt_s   = ZERO_C;
                end else if (cnt_r == DB_C) begin
                    state_s  = HELD;
                    cnt_s    = ZERO_C;
                    press_s  = 1'b1;
                    level_s  = ~level_r;
                    stable_s = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                    rpt_s    = 1'b0;
`endif
                end else begin
                    cnt_s = cnt_r + ONE_C;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_s = RELEASE_WAIT;
                    cnt_s   = ONE_C;
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    // First repeat waits the long delay, later ones use the period.
                    if (cnt_r == (rpt_r ? RPT_PER_C : RPT_DLY_C)) begin
                        press_s = 1'b1;
                        cnt_s   = ZERO_C;
                        rpt_s   = 1'b1;
                    end else if (cnt_r != CNT_MAX_C) begin
                        cnt_s   = cnt_r + ONE_C;
                    end else begin
                        cnt_s   = cnt_r;
                    end
`else
                    cnt_s = ZERO_C;
`endif
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_s = HELD;
                    cnt_s   = ZERO_C;
`ifdef BTN_AUTO_REPEAT_EN
                    rpt_s   = 1'b0;
`endif
                end else if (cnt_r == DB_C) begin
                    state_s  = IDLE;
                    cnt_s    = ZERO_C;
                    stable_s = 1'b0;
                end else begin
                    cnt_s = cnt_r + ONE_C;
                end
            end
            default: begin
                state_s  = IDLE;
                cnt_s    = ZERO_C;
                stable_s = 1'b0;
            end
        endcase
    end

    assign o_press  = press_r;
    assign o_level  = level_r;
    assign o_stable = stable_r;

endmodule

// File: tb/tb_push_button_toggle.sv
// Directed bench for push_button_toggle against a run-length behavioural model of the button.
module tb_push_button_toggle;

    localparam int DB  = 4;
    localparam int RDL = 10;
    localparam int RPR = 3;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_btn = 1'b0;
    logic o_press, o_level, o_stable;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;
    int pq[$];
    int exp_q[$];

    // model: raw pin delayed two samples, then counted as runs of disagreement with the stable state
    bit m_s1 = 1'b0, m_s2 = 1'b0;
    bit m_stable = 1'b0, m_level = 1'b0, m_press = 1'b0;
    int run = 0, since = 0;
    bit first = 1'b1, gap = 1'b0;

    push_button_toggle #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RDL),
        .REPEAT_PERIOD(RPR),
        .CNT_W(8)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_btn(i_btn),
        .o_press(o_press),
        .o_level(o_level),
        .o_stable(o_stable)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_step();
        bit bs;
        if (i_rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_stable = 1'b0; m_level = 1'b0; m_press = 1'b0;
            run = 0; since = 0; first = 1'b1; gap = 1'b0;
        end else begin
            bs = m_s2;
            m_s2 = m_s1;
            m_s1 = i_btn;
            m_press = 1'b0;
            if (bs != m_stable) run++;
            else run = 0;
            if (run == DB + 1) begin
                m_stable = bs;
                run = 0;
                if (bs) begin
                    m_press = 1'b1;
                    m_level = !m_level;
                    since = 0; first = 1'b1; gap = 1'b0;
                end
            end else if (m_stable) begin
`ifdef BTN_AUTO_REPEAT_EN
                if (!bs) begin
                    gap = 1'b1;
                end else if (gap) begin
                    gap = 1'b0; since = 0; first = 1'b1;
                end else begin
                    since++;
                    if (since == (first ? RDL + 1 : RPR + 1)) begin
                        m_press = 1'b1; since = 0; first = 1'b0;
                    end
                end
`endif
            end
        end
    endtask

    task automatic check(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_no, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        model_step();
        check("o_press", o_press, m_press);
        check("o_level", o_level, m_level);
        check("o_stable", o_stable, m_stable);
        if (m_press) pq.push_back(edge_no);
        edge_no++;
    endtask

    task automatic run_n(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic start_window();
        edge_no = 0;
        pq.delete();
    endtask

    task automatic check_q(string name);
        string sa, se;
        bit ok;
        sa = ""; se = "";
        foreach (pq[i]) sa = {sa, $sformatf("%0d ", pq[i])};
        foreach (exp_q[i]) se = {se, $sformatf("%0d ", exp_q[i])};
        ok = (pq.size() == exp_q.size());
        if (ok) foreach (pq[i]) if (pq[i] != exp_q[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: pulse edges [%s], expected [%s]", name, sa, se);
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        run_n(2);
        i_rst = 1'b0;
    endtask

    initial begin
        // reset held with the button pressed: everything stays low
        i_rst = 1'b1;
        i_btn = 1'b1;
        run_n(4);
        check("rst_press", o_press, 1'b0);
        check("rst_level", o_level, 1'b0);
        check("rst_stable", o_stable, 1'b0);
        i_rst = 1'b0;
        start_window();
        run_n(10);
        exp_q = '{6};
        check_q("rst_release_pulse");
        check("rst_release_level", o_level, 1'b1);
        i_btn = 1'b0;
        run_n(8);

        // clean press, release latency, second press toggles back
        do_reset();
        i_btn = 1'b1;
        start_window();
        run_n(8);
        exp_q = '{6};
        check_q("clean_press");
        check("clean_level", o_level, 1'b1);
        check("clean_stable", o_stable, 1'b1);
        i_btn = 1'b0;
        run_n(6);
        check("release_before", o_stable, 1'b1);
        run_n(1);
        check("release_at6", o_stable, 1'b0);
        run_n(2);
        i_btn = 1'b1;
        start_window();
        run_n(8);
        check_q("second_press");
        check("second_level", o_level, 1'b0);
        i_btn = 1'b0;
        run_n(8);

        // press bounce shorter than the debounce window
        do_reset();
        start_window();
        i_btn = 1'b1; run_n(3);
        i_btn = 1'b0; run_n(1);
        i_btn = 1'b1; run_n(3);
        i_btn = 1'b0; run_n(10);
        exp_q.delete();
        check_q("bounce");
        check("bounce_level", o_level, 1'b0);
        check("bounce_stable", o_stable, 1'b0);

        // release bounce while held
        do_reset();
        i_btn = 1'b1;
        run_n(8);
        start_window();
        i_btn = 1'b0; run_n(2);
        i_btn = 1'b1; run_n(4);
        exp_q.delete();
        check_q("release_bounce");
        check("rb_stable", o_stable, 1'b1);
        check("rb_level", o_level, 1'b1);
        i_btn = 1'b0;
        run_n(8);
        check("rb_final_stable", o_stable, 1'b0);

        // long hold: repeats only when compiled in
        do_reset();
        i_btn = 1'b1;
        start_window();
        run_n(40);
        i_btn = 1'b0;
        run_n(10);
`ifdef BTN_AUTO_REPEAT_EN
        exp_q = '{6, 17, 21, 25, 29, 33, 37, 41};
`else
        exp_q = '{6};
`endif
        check_q("auto_repeat");
        check("repeat_level", o_level, 1'b1);

        // reset during press debounce, then a full new latency
        do_reset();
        i_btn = 1'b1;
        start_window();
        run_n(5);
        i_rst = 1'b1;
        run_n(2);
        i_rst = 1'b0;
        exp_q.delete();
        check_q("mid_reset_nopulse");
        start_window();
        run_n(8);
        exp_q = '{6};
        check_q("mid_reset_relatency");
        check("mid_reset_level", o_level, 1'b1);
        i_btn = 1'b0;
        run_n(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
